// File: rtl/instruction_fetch.sv
// Fetch stage: presents the PC to a synchronous ROM, registers the returned word,
// hands it to decode over valid/ready, and reloads the PC for JMP/BRZ and back-pressure.
module instruction_fetch #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              Clock,
    input  logic              nReset,
    input  logic [ADDR_W-1:0] CounterValue,
    output logic [ADDR_W-1:0] LoadValue,
    output logic              LoadEnable,
    output logic [ADDR_W-1:0] MemAddr,
    input  logic [DATA_W-1:0] MemData,
    input  logic              ZeroFlag,
    output logic [DATA_W-1:0] InstrOut,
    output logic [ADDR_W-1:0] InstrAddr,
    output logic              InstrValid,
    input  logic              InstrReady,
    output logic [1:0]        DbgState
);

    // Handshake: decode takes InstrOut/InstrAddr on any cycle where InstrValid && InstrReady;
    // while InstrValid is high and InstrReady low, all three outputs hold unchanged.

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STALL  = 2'd2,
        ST_REFILL = 2'd3
    } fetch_state_e;

    localparam logic [3:0] OP_JMP = 4'hE;
    localparam logic [3:0] OP_BRZ = 4'hF;

    logic              pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0] pend_addr_q,  pend_addr_d;
    logic [DATA_W-1:0] instr_out_q,  instr_out_d;
    logic [ADDR_W-1:0] instr_addr_q, instr_addr_d;
    logic              instr_valid_q, instr_valid_d;

    logic              hs;
    logic              stall;
    logic              redirect;
    logic [3:0]        opcode;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] brz_offset;
    logic              load_en;
    logic [ADDR_W-1:0] load_val;
    fetch_state_e      state;

    assign MemAddr    = CounterValue;
    assign InstrOut   = instr_out_q;
    assign InstrAddr  = instr_addr_q;
    assign InstrValid = instr_valid_q;
    assign LoadEnable = load_en;
    assign LoadValue  = load_val;
    assign DbgState   = state;

    assign hs         = instr_valid_q && InstrReady;
    assign stall      = instr_valid_q && !InstrReady;
    assign opcode     = instr_out_q[DATA_W-1 -: 4];
    assign brz_offset = {{(ADDR_W-9){instr_out_q[8]}}, instr_out_q[8:0]};

    // Branch resolution on the instruction currently being handed to decode.
    always_comb begin
        redirect = 1'b0;
        target   = '0;
        if (hs) begin
            if (opcode == OP_JMP) begin
                redirect = 1'b1;
                target   = {{(ADDR_W-12){1'b0}}, instr_out_q[11:0]};
            end else if (opcode == OP_BRZ && ZeroFlag) begin
                redirect = 1'b1;
                target   = instr_addr_q + ADDR_W'(1) + brz_offset;
            end
        end
    end

    // Stall re-points the PC at the successor so the word after the held one is refetched.
    always_comb begin
        load_en  = 1'b0;
        load_val = '0;
        if (redirect) begin
            load_en  = 1'b1;
            load_val = target;
        end else if (stall) begin
            load_en  = 1'b1;
            load_val = instr_addr_q + ADDR_W'(1);
        end
    end

    always_comb begin
        pend_addr_d   = CounterValue;
        pend_valid_d  = !(stall || redirect);
        instr_out_d   = instr_out_q;
        instr_addr_d  = instr_addr_q;
        instr_valid_d = instr_valid_q;
        if (stall) begin
            instr_valid_d = 1'b1;
        end else if (redirect) begin
            instr_valid_d = 1'b0;
        end else if (pend_valid_q) begin
            instr_out_d   = MemData;
            instr_addr_d  = pend_addr_q;
            instr_valid_d = 1'b1;
        end else begin
            instr_valid_d = 1'b0;
        end
    end

    // Accepting with nothing pending only happens on the release cycle after a stall.
    always_comb begin
        state = ST_FILL;
        if (stall) begin
            state = ST_STALL;
        end else if (instr_valid_q && !pend_valid_q) begin
            state = ST_REFILL;
        end else if (instr_valid_q) begin
            state = ST_RUN;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            pend_valid_q  <= 1'b0;
            pend_addr_q   <= '0;
            instr_out_q   <= '0;
            instr_addr_q  <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            pend_valid_q  <= pend_valid_d;
            pend_addr_q   <= pend_addr_d;
            instr_out_q   <= instr_out_d;
            instr_addr_q  <= instr_addr_d;
            instr_valid_q <= instr_valid_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: models the PC and a synchronous ROM,
// and checks sequencing, jumps, branches, stalls, reset and address wrap.
module tb_instruction_fetch;

    logic        Clock = 1'b0;
    logic        nReset = 1'b0;
    logic [15:0] CounterValue;
    logic [15:0] LoadValue;
    logic        LoadEnable;
    logic [15:0] MemAddr;
    logic [15:0] MemData = 16'h0;
    logic        ZeroFlag = 1'b0;
    logic [15:0] InstrOut;
    logic [15:0] InstrAddr;
    logic        InstrValid;
    logic        InstrReady = 1'b1;
    logic [1:0]  DbgState;

    int n_tests = 0;
    int n_fail  = 0;
    int mode    = 0;

    localparam logic [1:0] S_FILL = 2'd0, S_RUN = 2'd1, S_STALL = 2'd2, S_REFILL = 2'd3;

    instruction_fetch #(.ADDR_W(16), .DATA_W(16)) dut (
        .Clock(Clock), .nReset(nReset), .CounterValue(CounterValue),
        .LoadValue(LoadValue), .LoadEnable(LoadEnable), .MemAddr(MemAddr),
        .MemData(MemData), .ZeroFlag(ZeroFlag), .InstrOut(InstrOut),
        .InstrAddr(InstrAddr), .InstrValid(InstrValid), .InstrReady(InstrReady),
        .DbgState(DbgState)
    );

    always #5 Clock = ~Clock;

    // Program counter model: reload takes priority over increment.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) CounterValue <= 16'h0;
        else         CounterValue <= LoadEnable ? LoadValue : CounterValue + 16'h1;
    end

    function automatic logic [15:0] rom_word(input logic [15:0] a);
        rom_word = a | 16'h1000;
        if (mode == 1 && a == 16'h0005) rom_word = 16'hE040;
        if (mode == 2 && a == 16'h0008) rom_word = 16'hF1FC;
        if (mode == 3 && a == 16'h0002) rom_word = 16'hF1F7;
    endfunction

    always @(posedge Clock) MemData <= rom_word(MemAddr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk_valid(input string tag, input logic [15:0] a);
        check({tag, "_valid"}, {31'h0, InstrValid}, 32'h1);
        check({tag, "_addr"}, {16'h0, InstrAddr}, {16'h0, a});
        check({tag, "_data"}, {16'h0, InstrOut}, {16'h0, rom_word(a)});
    endtask

    task automatic chk_bubble(input string tag);
        check({tag, "_bubble"}, {31'h0, InstrValid}, 32'h0);
    endtask

    task automatic chk_load(input string tag, input logic le, input logic [15:0] lv);
        #1;
        check({tag, "_load_en"}, {31'h0, LoadEnable}, {31'h0, le});
        if (le) check({tag, "_load_val"}, {16'h0, LoadValue}, {16'h0, lv});
    endtask

    task automatic do_reset(input int m);
        mode       = m;
        InstrReady = 1'b1;
        ZeroFlag   = 1'b0;
        nReset     = 1'b0;
        @(posedge Clock);
        @(posedge Clock);
        #1;
        check("rst_valid", {31'h0, InstrValid}, 32'h0);
        check("rst_out", {16'h0, InstrOut}, 32'h0);
        check("rst_addr", {16'h0, InstrAddr}, 32'h0);
        check("rst_load_en", {31'h0, LoadEnable}, 32'h0);
        check("rst_load_val", {16'h0, LoadValue}, 32'h0);
        nReset = 1'b1;
        tick();
        chk_bubble("rst_edge1");
        tick();
        chk_valid("rst_edge2", 16'h0000);
    endtask

    initial begin
        logic [15:0] a;

        // Sequential streaming after reset
        do_reset(0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk_valid("seq", 16'(i));
            chk_load("seq", 1'b0, 16'h0);
        end
        check("seq_state", {30'h0, DbgState}, {30'h0, S_RUN});

        // Four stalled cycles on addr 3, then one bubble and addr 4 onward
        do_reset(0);
        for (int i = 1; i <= 2; i++) begin
            tick();
            chk_valid("pre_stall", 16'(i));
        end
        tick();
        InstrReady = 1'b0;
        chk_valid("stall0", 16'h0003);
        chk_load("stall0", 1'b1, 16'h0004);
        check("stall_state", {30'h0, DbgState}, {30'h0, S_STALL});
        repeat (3) begin
            tick();
            chk_valid("stall_hold", 16'h0003);
            chk_load("stall_hold", 1'b1, 16'h0004);
        end
        tick();
        InstrReady = 1'b1;
        chk_valid("release", 16'h0003);
        chk_load("release", 1'b0, 16'h0);
        check("release_state", {30'h0, DbgState}, {30'h0, S_REFILL});
        tick();
        chk_bubble("refill");
        for (int i = 4; i <= 7; i++) begin
            tick();
            chk_valid("post_stall", 16'(i));
        end

        // JMP 0x040 at addr 5, then a one-cycle reset pulse mid-stream
        do_reset(1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk_valid("pre_jmp", 16'(i));
        end
        tick();
        chk_valid("jmp", 16'h0005);
        chk_load("jmp", 1'b1, 16'h0040);
        tick();
        chk_bubble("jmp_b1");
        chk_load("jmp_b1", 1'b0, 16'h0);
        tick();
        chk_bubble("jmp_b2");
        tick();
        chk_valid("jmp_tgt", 16'h0040);
        tick();
        chk_valid("jmp_tgt1", 16'h0041);
        tick();
        nReset = 1'b0;
        #1;
        check("pulse_valid", {31'h0, InstrValid}, 32'h0);
        check("pulse_load_en", {31'h0, LoadEnable}, 32'h0);
        @(posedge Clock);
        #1;
        nReset = 1'b1;
        tick();
        chk_bubble("pulse_edge1");
        tick();
        chk_valid("pulse_edge2", 16'h0000);
        check("fill_state", {30'h0, DbgState}, {30'h0, S_RUN});

        // BRZ -4 at addr 8: taken with ZeroFlag=1, falls through with ZeroFlag=0
        do_reset(2);
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk_valid("pre_brz", 16'(i));
        end
        tick();
        ZeroFlag = 1'b1;
        chk_valid("brz_taken", 16'h0008);
        chk_load("brz_taken", 1'b1, 16'h0005);
        tick();
        ZeroFlag = 1'b0;
        chk_bubble("brz_b1");
        check("brz_fill_state", {30'h0, DbgState}, {30'h0, S_FILL});
        tick();
        chk_bubble("brz_b2");
        for (int i = 5; i <= 7; i++) begin
            tick();
            chk_valid("brz_tgt", 16'(i));
        end
        tick();
        chk_valid("brz_not", 16'h0008);
        chk_load("brz_not", 1'b0, 16'h0);
        tick();
        chk_valid("brz_fall", 16'h0009);
        tick();
        chk_valid("brz_fall1", 16'h000A);

        // BRZ -9 at addr 2 wraps to 0xFFFA; sequential flow crosses 0xFFFF -> 0x0000
        do_reset(3);
        tick();
        chk_valid("pre_wrap", 16'h0001);
        tick();
        ZeroFlag = 1'b1;
        chk_valid("brz_wrap", 16'h0002);
        chk_load("brz_wrap", 1'b1, 16'hFFFA);
        tick();
        ZeroFlag = 1'b0;
        chk_bubble("wrap_b1");
        tick();
        chk_bubble("wrap_b2");
        a = 16'hFFFA;
        repeat (8) begin
            tick();
            chk_valid("wrap_seq", a);
            chk_load("wrap_seq", 1'b0, 16'h0);
            a = a + 16'h1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
